pipelined_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor.
- Splits a WIDTH-bit operation into STAGES chunks of WIDTH/STAGES bits; one chunk is added per pipeline stage and the carry is registered between stages.
- Valid/ready handshake on input and output; sustained throughput of one operation per cycle.
- Sits between upstream operand producers (neuron state / weight accumulation paths) and downstream consumers.

---
 rtl/adder_stage.sv | 35 +++
 rtl/full_adder.sv | 17 +
 rtl/pipelined_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_adder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_stage.sv
// adder_stage: combinational CW-bit ripple-carry chain built from full_adder cells.
//   a, b     : CW-bit chunk operands
//   cin      : carry into bit 0 of the chunk
//   s        : CW-bit chunk sum
//   cout     : carry out of the chunk MSB
//   c_msb_in : carry into the chunk MSB (used for signed overflow)
module adder_stage #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          c_msb_in
);

    logic [CW:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .s    (s[i]),
            .cout (carry_s[i+1])
        );
    end

    assign cout     = carry_s[CW];
    assign c_msb_in = carry_s[CW-1];

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder/subtractor split into STAGES ripple chunks,
// one chunk per pipeline stage, with the inter-chunk carry registered.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = global advance)
//   a, b, cin, sub      : operands; sub=1 computes a-b-cin
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result mod 2^WIDTH, raw MSB carry, signed overflow
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    localparam int CW = WIDTH / STAGES;

    // Stage registers. Operand registers hold the not-yet-added bits
    // right-justified, so each stage always consumes the low CW bits.
    // The partial sum is shifted in from the top, so after the last stage
    // chunk 0 sits at bit 0.
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] carry_r;
    logic [WIDTH-1:0]  sum_r [STAGES];
    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  b_r   [STAGES];
    logic              ovf_r;

    logic              advance_s;
    logic [WIDTH-1:0]  src_a_s   [STAGES];
    logic [WIDTH-1:0]  src_b_s   [STAGES];
    logic [WIDTH-1:0]  src_sum_s [STAGES];
    logic [WIDTH-1:0]  nxt_sum_s [STAGES];
    logic [STAGES-1:0] src_c_s;
    logic [STAGES-1:0] src_v_s;
    logic [STAGES-1:0] co_s;
    logic              cm_s      [STAGES];
    logic [CW-1:0]     s_s       [STAGES];

    // The stall is global: everything moves only when the output slot frees.
    assign advance_s = !valid_r[STAGES-1] || out_ready;
    assign in_ready  = advance_s;

    // Select each stage's source: transformed inputs for stage 0, previous register otherwise.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_v_s[k]   = in_valid;
                src_a_s[k]   = a;
                src_b_s[k]   = sub ? ~b : b;
                src_c_s[k]   = sub ? ~cin : cin;
                src_sum_s[k] = {WIDTH{1'b0}};
            end else begin
                src_v_s[k]   = valid_r[k-1];
                src_a_s[k]   = a_r[k-1];
                src_b_s[k]   = b_r[k-1];
                src_c_s[k]   = carry_r[k-1];
                src_sum_s[k] = sum_r[k-1];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        adder_stage #(.CW(CW)) u_stage (
            .a        (src_a_s[g][CW-1:0]),
            .b        (src_b_s[g][CW-1:0]),
            .cin      (src_c_s[g]),
            .s        (s_s[g]),
            .cout     (co_s[g]),
            .c_msb_in (cm_s[g])
        );
    end

    // Shift the new chunk in at the top of the partial sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_sum_s[k] = (src_sum_s[k] >> CW) | (WIDTH'(s_s[k]) << (WIDTH - CW));
        end
    end

    // Pipeline registers: clear on reset, shift all stages together on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
            ovf_r   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                sum_r[k] <= {WIDTH{1'b0}};
                a_r[k]   <= {WIDTH{1'b0}};
                b_r[k]   <= {WIDTH{1'b0}};
            end
        end else if (advance_s) begin
            valid_r <= src_v_s;
            carry_r <= co_s;
            ovf_r   <= cm_s[STAGES-1] ^ co_s[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                sum_r[k] <= nxt_sum_s[k];
                a_r[k]   <= src_a_s[k] >> CW;
                b_r[k]   <= src_b_s[k] >> CW;
            end
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign cout      = carry_r[STAGES-1];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    res_t   exp_q[$];
    logic   stall_prev = 1'b0;
    res_t   held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t ref_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                    input logic icin, input logic isub);
        int   ua, ub, sa, sb, t, st;
        res_t r;
        ua = int'(ia);
        ub = int'(ib);
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        if (isub) begin
            t   = ua - ub - int'(icin);
            st  = sa - sb - int'(icin);
            r.c = (t >= 0);
        end else begin
            t   = ua + ub + int'(icin);
            st  = sa + sb + int'(icin);
            r.c = (t > 65535);
        end
        r.s = t[15:0];
        r.o = (st > 32767) || (st < -32768);
        return r;
    endfunction

    // One handshake cycle with scoreboard checking of any result that drains.
    task automatic cycle(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin, input logic isub, input logic ordy,
                         output logic fired);
        res_t e;
        @(negedge clk);
        in_valid  = v;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        out_ready = ordy;
        #1;
        chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (stall_prev) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, sum}, {16'd0, held.s});
            chk("hold_cout", {31'd0, cout}, {31'd0, held.c});
            chk("hold_ovf", {31'd0, ovf}, {31'd0, held.o});
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sum", {16'd0, sum}, {16'd0, e.s});
                chk("sb_cout", {31'd0, cout}, {31'd0, e.c});
                chk("sb_ovf", {31'd0, ovf}, {31'd0, e.o});
            end
        end
        fired = in_valid && in_ready;
        if (fired) exp_q.push_back(ref_op(ia, ib, icin, isub));
        stall_prev = out_valid && !out_ready;
        held.s = sum;
        held.c = cout;
        held.o = ovf;
        @(posedge clk);
    endtask

    // Single isolated operation on an empty pipeline with exact latency checks.
    task automatic run_one(input vec_t vv, input string tag);
        stall_prev = 1'b0;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = vv.a;
        b         = vv.b;
        cin       = vv.cin;
        sub       = vv.sub;
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        for (int i = 1; i < S; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, vv.s});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, vv.c});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, vv.o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic        fired;
        logic        pat[7];
        int          idx;
        int          cyc;
        vec_t        nv;

        vecs[0] = '{a:16'h1234, b:16'h0FCD, cin:1'b0, sub:1'b0, s:16'h2201, c:1'b0, o:1'b0};
        vecs[1] = '{a:16'hFFFF, b:16'h0000, cin:1'b1, sub:1'b0, s:16'h0000, c:1'b1, o:1'b0};
        vecs[2] = '{a:16'h7FFF, b:16'h0001, cin:1'b0, sub:1'b0, s:16'h8000, c:1'b0, o:1'b1};
        vecs[3] = '{a:16'h0005, b:16'h0007, cin:1'b0, sub:1'b1, s:16'hFFFE, c:1'b0, o:1'b0};
        vecs[4] = '{a:16'h0007, b:16'h0005, cin:1'b1, sub:1'b1, s:16'h0001, c:1'b1, o:1'b0};
        vecs[5] = '{a:16'h8000, b:16'h0001, cin:1'b0, sub:1'b1, s:16'h7FFF, c:1'b1, o:1'b1};
        vecs[6] = '{a:16'hFFFF, b:16'hFFFF, cin:1'b1, sub:1'b0, s:16'hFFFF, c:1'b1, o:1'b0};
        vecs[7] = '{a:16'h8000, b:16'h8000, cin:1'b0, sub:1'b0, s:16'h0000, c:1'b1, o:1'b1};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 8; i++) run_one(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back with fixed backpressure pattern.
        stall_prev = 1'b0;
        idx = 1;
        cyc = 0;
        while (idx <= 8 && cyc < 200) begin
            cycle(1'b1, 16'(idx), 16'(16'h0100 * idx), 1'b0, 1'b0, pat[cyc % 7], fired);
            if (fired) idx++;
            cyc++;
        end
        chk("bp_all_accepted", idx, 9);
        while (exp_q.size() != 0 && cyc < 300) begin
            cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, pat[cyc % 7], fired);
            cyc++;
        end
        chk("bp_drained", exp_q.size(), 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, fired);
        end
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, fired);
            cyc++;
        end
        chk("rand_drained", exp_q.size(), 0);

        // Reset with operations in flight.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'(16'h0011 * (i + 1)), 16'h0101, 1'b0, 1'b0, 1'b1, fired);
        end
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, fired);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_sum", {16'd0, sum}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, fired);
            #1;
            chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        nv = '{a:16'h4321, b:16'h1111, cin:1'b1, sub:1'b1, s:16'h320F, c:1'b1, o:1'b0};
        run_one(nv, "post_rst_op");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
